// File: rtl/interposer_arbiter.sv
// ============================================================================
// interposer_arbiter: round-robin arbiter driving per-node send/receive/bypass
// controls for an 8-node ring interposer.  Revision: 1.0
// ============================================================================
`default_nettype none

module interposer_arbiter #(
    parameter int XFER_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] request_in,
    output logic [23:0] control_out,
    output logic        busy,
    output logic [2:0]  grant_node,
    output logic        err_valid,
    output logic [2:0]  err_node
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0] state;
    logic [3:0] phase;
    logic [2:0] rr_ptr;
    logic [7:0] mask;

    logic [7:0] req_valid;
    logic [2:0] req_dst [8];
    logic [7:0] reject;
    logic [7:0] eligible;
    logic [7:0] mask_next;
    logic       win_found;
    logic [2:0] win_node;
    logic [2:0] err_sel;

    // Walk the ring upward from src: bypass every hop until dst is reached.
    function automatic logic [23:0] route(input logic [2:0] src, input logic [2:0] dst);
        logic [23:0] ctl;
        logic [2:0]  node;
        logic        hit;
        ctl = '0;
        hit = 1'b0;
        for (int i = 1; i < 8; i++) begin
            node = src + 3'(i);
            if (!hit) begin
                if (node == dst) begin
                    ctl[int'(node) * 3 +: 3] = 3'b010;
                    hit = 1'b1;
                end else begin
                    ctl[int'(node) * 3 +: 3] = 3'b001;
                end
            end
        end
        ctl[int'(src) * 3 +: 3] = 3'b100;
        return ctl;
    endfunction

    always_comb begin
        req_valid = '0;
        reject    = '0;
        eligible  = '0;
        mask_next = mask;
        for (int n = 0; n < 8; n++) begin
            req_valid[n] = request_in[4 * n + 3];
            req_dst[n]   = request_in[4 * n +: 3];
            reject[n]    = req_valid[n] && (req_dst[n] == 3'(n)) && !mask[n];
            eligible[n]  = req_valid[n] && (req_dst[n] != 3'(n)) && !mask[n];
            if (!req_valid[n]) begin
                mask_next[n] = 1'b0;
            end else if (reject[n]) begin
                mask_next[n] = 1'b1;
            end
        end
    end

    always_comb begin
        logic [2:0] idx;
        win_found = 1'b0;
        win_node  = '0;
        for (int i = 0; i < 8; i++) begin
            idx = rr_ptr + 3'(i);
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_node  = idx;
            end
        end
    end

    // Lowest-numbered rejected node is the one reported.
    always_comb begin
        err_sel = '0;
        for (int n = 7; n >= 0; n--) begin
            if (reject[n]) begin
                err_sel = 3'(n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase       <= '0;
            rr_ptr      <= '0;
            mask        <= '0;
            control_out <= '0;
            busy        <= 1'b0;
            grant_node  <= '0;
            err_valid   <= 1'b0;
            err_node    <= '0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mask <= mask_next;
                    if (|reject) begin
                        err_valid <= 1'b1;
                        err_node  <= err_sel;
                    end
                    if (win_found) begin
                        state       <= ST_XFER;
                        phase       <= '0;
                        control_out <= route(win_node, req_dst[win_node]);
                        grant_node  <= win_node;
                        rr_ptr      <= win_node + 3'd1;
                        busy        <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (phase == 4'(XFER_CYCLES - 1)) begin
                        control_out <= '0;
                        phase       <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (phase == 4'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                        phase <= '0;
                        busy  <= 1'b0;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    phase       <= '0;
                    control_out <= '0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_interposer_arbiter.sv
// Directed testbench for interposer_arbiter: default timing instance (a) and
// XFER_CYCLES=3 / GAP_CYCLES=0 instance (b) share clock, reset and requests.
`default_nettype none

module tb_interposer_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] request_in = '0;

    logic [23:0] a_control, b_control;
    logic        a_busy, b_busy;
    logic [2:0]  a_grant, b_grant;
    logic        a_err_valid, b_err_valid;
    logic [2:0]  a_err_node, b_err_node;

    int checks = 0;
    int errors = 0;

    interposer_arbiter #(.XFER_CYCLES(1), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .request_in(request_in),
        .control_out(a_control), .busy(a_busy), .grant_node(a_grant),
        .err_valid(a_err_valid), .err_node(a_err_node)
    );

    interposer_arbiter #(.XFER_CYCLES(3), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .request_in(request_in),
        .control_out(b_control), .busy(b_busy), .grant_node(b_grant),
        .err_valid(b_err_valid), .err_node(b_err_node)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        request_in = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        request_in = 32'h00E0C009;
        step();
        step();
        checks++; if (a_control !== 24'h0) begin errors++; $display("FAIL reset_control: got %h expected %h", a_control, 24'h0); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_grant !== 3'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", a_grant); end
        checks++; if (a_err_valid !== 1'b0 || a_err_node !== 3'd0) begin errors++; $display("FAIL reset_err: got %b/%0d expected 0/0", a_err_valid, a_err_node); end
        checks++; if (b_control !== 24'h0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_b: got %h/%b expected 0/0", b_control, b_busy); end
        request_in = '0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        request_in = 32'h00000E00;
        step();
        checks++; if (a_control !== 24'h089300) begin errors++; $display("FAIL single_control: got %h expected %h", a_control, 24'h089300); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", a_busy); end
        checks++; if (a_grant !== 3'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", a_grant); end
        request_in = '0;
        step();
        checks++; if (a_control !== 24'h0 || a_busy !== 1'b1) begin errors++; $display("FAIL single_gap: got %h/%b expected 0/1", a_control, a_busy); end
        step();
        checks++; if (a_control !== 24'h0 || a_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %h/%b expected 0/0", a_control, a_busy); end
    endtask

    task automatic test_wrap();
        do_reset();
        request_in = 32'h09000000;
        step();
        checks++; if (a_control !== 24'h300011) begin errors++; $display("FAIL wrap_control: got %h expected %h", a_control, 24'h300011); end
        checks++; if (a_grant !== 3'd6) begin errors++; $display("FAIL wrap_grant: got %0d expected 6", a_grant); end
        request_in = '0;
        step();
        step();
    endtask

    task automatic test_fairness();
        logic [2:0]  exp_grant [5];
        logic [23:0] exp_ctl   [5];
        exp_grant = '{3'd0, 3'd3, 3'd5, 3'd0, 3'd3};
        exp_ctl   = '{24'h000014, 24'h002800, 24'h0A0000, 24'h000014, 24'h002800};
        do_reset();
        request_in = 32'h00E0C009;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (a_grant !== exp_grant[i] || a_control !== exp_ctl[i]) begin errors++; $display("FAIL fair_grant[%0d]: got %0d/%h expected %0d/%h", i, a_grant, a_control, exp_grant[i], exp_ctl[i]); end
            step();
            checks++; if (a_control !== 24'h0 || a_busy !== 1'b1) begin errors++; $display("FAIL fair_gap[%0d]: got %h/%b expected 0/1", i, a_control, a_busy); end
            step();
            checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL fair_idle[%0d]: got %b expected 0", i, a_busy); end
        end
        request_in = '0;
    endtask

    task automatic test_self_address();
        do_reset();
        request_in = 32'h000C0000;
        step();
        checks++; if (a_err_valid !== 1'b1 || a_err_node !== 3'd4) begin errors++; $display("FAIL self_err: got %b/%0d expected 1/4", a_err_valid, a_err_node); end
        checks++; if (a_busy !== 1'b0 || a_control !== 24'h0) begin errors++; $display("FAIL self_no_xfer: got %b/%h expected 0/0", a_busy, a_control); end
        step();
        checks++; if (a_err_valid !== 1'b0) begin errors++; $display("FAIL self_pulse: got %b expected 0", a_err_valid); end
        step();
        checks++; if (a_err_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL self_masked: got %b/%b expected 0/0", a_err_valid, a_busy); end
        request_in = '0;
        step();
        checks++; if (a_err_valid !== 1'b0) begin errors++; $display("FAIL self_drop: got %b expected 0", a_err_valid); end
        request_in = 32'h000C0000;
        step();
        checks++; if (a_err_valid !== 1'b1 || a_err_node !== 3'd4) begin errors++; $display("FAIL self_reassert: got %b/%0d expected 1/4", a_err_valid, a_err_node); end
        request_in = '0;
        step();
    endtask

    task automatic test_same_cycle();
        do_reset();
        request_in = 32'h00E0B090;
        step();
        checks++; if (a_err_valid !== 1'b1 || a_err_node !== 3'd1) begin errors++; $display("FAIL same_err: got %b/%0d expected 1/1", a_err_valid, a_err_node); end
        checks++; if (a_grant !== 3'd5 || a_control !== 24'h0A0000 || a_busy !== 1'b1) begin errors++; $display("FAIL same_xfer: got %0d/%h/%b expected 5/0a0000/1", a_grant, a_control, a_busy); end
        step();
        checks++; if (a_err_valid !== 1'b0) begin errors++; $display("FAIL same_err_pulse: got %b expected 0", a_err_valid); end
        step();
        step();
        checks++; if (a_grant !== 3'd5 || a_control !== 24'h0A0000 || a_err_valid !== 1'b0) begin errors++; $display("FAIL same_regrant: got %0d/%h/%b expected 5/0a0000/0", a_grant, a_control, a_err_valid); end
        request_in = '0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        request_in = 32'h0000C009;
        step();
        checks++; if (b_control !== 24'h000014 || b_grant !== 3'd0 || b_busy !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%0d/%b expected 000014/0/1", b_control, b_grant, b_busy); end
        request_in = 32'h09000000;
        step();
        checks++; if (b_control !== 24'h000014) begin errors++; $display("FAIL b2b_hold2: got %h expected 000014", b_control); end
        step();
        checks++; if (b_control !== 24'h000014 || b_busy !== 1'b1) begin errors++; $display("FAIL b2b_hold3: got %h/%b expected 000014/1", b_control, b_busy); end
        step();
        checks++; if (b_control !== 24'h0 || b_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %h/%b expected 0/0", b_control, b_busy); end
        step();
        checks++; if (b_control !== 24'h300011 || b_grant !== 3'd6) begin errors++; $display("FAIL b2b_second: got %h/%0d expected 300011/6", b_control, b_grant); end
        request_in = '0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        request_in = 32'h0000C000;
        step();
        checks++; if (b_control !== 24'h002800 || b_grant !== 3'd3) begin errors++; $display("FAIL rmid_start: got %h/%0d expected 002800/3", b_control, b_grant); end
        step();
        reset = 1'b1;
        step();
        checks++; if (b_control !== 24'h0 || b_busy !== 1'b0 || b_grant !== 3'd0) begin errors++; $display("FAIL rmid_abort: got %h/%b/%0d expected 0/0/0", b_control, b_busy, b_grant); end
        reset = 1'b0;
        request_in = 32'h00E00009;
        step();
        checks++; if (b_grant !== 3'd0 || b_control !== 24'h000014) begin errors++; $display("FAIL rmid_ptr: got %0d/%h expected 0/000014", b_grant, b_control); end
        request_in = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_self_address();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
